// File: rtl/wb_cmd_pkg.sv
// Shared types and defaults for the wb_cmd_master Wishbone command master.
package wb_cmd_pkg;

  localparam int unsigned DefaultAw      = 32;
  localparam int unsigned DefaultDw      = 32;
  localparam int unsigned DefaultTimeout = 255;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } state_e;

  // Sized to the default widths; narrower instances use the low bits.
  typedef struct packed {
    logic                     we;
    logic [DefaultAw-1:0]     adr;
    logic [DefaultDw-1:0]     dat;
    logic [DefaultDw/8-1:0]   sel;
  } cmd_t;

endpackage

// File: rtl/wb_cmd_watchdog.sv
// Ack watchdog for wb_cmd_master: counts unacknowledged bus cycles and flags expiry.
module wb_cmd_watchdog #(
  parameter int unsigned Timeout = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam logic [15:0] Limit = 16'(Timeout);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (run_i) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = run_i && (count_q == Limit);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone B4 classic master: one bus cycle per valid/ready command, result on a response port.
// Define WB_CMD_MASTER_TIMEOUT_EN to build in the ack watchdog (aborts with rsp_err=1).
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int unsigned AW             = DefaultAw,
  parameter int unsigned DW             = DefaultDw,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeout
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,

  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,

  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,

  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i
);

  if (AW > DefaultAw || DW > DefaultDw || DW % 8 != 0) begin : g_bad_width
    $error("wb_cmd_master: AW/DW exceed package widths or DW not a byte multiple");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e          state_q, state_d;
  cmd_t            cmd_q, cmd_d;
  logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic            bus_active;
  logic            cmd_hs;
  logic            expired;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  logic            rsp_err_q, rsp_err_d;

  wb_cmd_watchdog #(
    .Timeout (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .clear_i   (cmd_hs),
    .run_i     (bus_active && !wbm_ack_i),
    .expired_o (expired)
  );

  assign rsp_err = rsp_err_q;
`else
  assign expired = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign cmd_hs = (state_q == StIdle) && cmd_valid;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    rsp_dat_d  = rsp_dat_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    rsp_err_d  = rsp_err_q;
`endif
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    bus_active = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_d.we  = cmd_we;
          cmd_d.adr = DefaultAw'(cmd_adr);
          cmd_d.dat = DefaultDw'(cmd_dat);
          cmd_d.sel = (DefaultDw / 8)'(cmd_sel);
          state_d   = StBus;
        end
      end
      StBus: begin
        bus_active = 1'b1;
        // Ack takes priority over a simultaneous watchdog expiry.
        if (wbm_ack_i) begin
          rsp_dat_d = cmd_q.we ? '0 : wbm_dat_i;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          rsp_err_d = 1'b0;
`endif
          state_d   = StResp;
        end else if (expired) begin
          rsp_dat_d = '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          rsp_err_d = 1'b1;
`endif
          state_d   = StResp;
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      rsp_dat_q <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      rsp_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      rsp_dat_q <= rsp_dat_d;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      rsp_err_q <= rsp_err_d;
`endif
    end
  end

  assign wbm_cyc_o = bus_active;
  assign wbm_stb_o = bus_active;
  assign wbm_we_o  = bus_active && cmd_q.we;
  assign wbm_adr_o = cmd_q.adr[AW-1:0];
  assign wbm_dat_o = cmd_q.dat[DW-1:0];
  assign wbm_sel_o = cmd_q.sel[DW/8-1:0];
  assign rsp_dat   = rsp_dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master; watchdog scenarios run when WB_CMD_MASTER_TIMEOUT_EN is set.
module tb_wb_cmd_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;

  // Slave model: acks when stb has been high for ack_delay previous cycles.
  logic        ack_en;
  int          ack_delay;
  int          stb_age;
  logic [31:0] slave_dat;

  int tests = 0;
  int fails = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) begin
    if (!wbm_stb_o) stb_age <= 0;
    else            stb_age <= stb_age + 1;
  end

  assign wbm_ack_i = wbm_stb_o && ack_en && (stb_age == ack_delay);
  assign wbm_dat_i = slave_dat;

  wb_cmd_master #(
    .AW             (32),
    .DW             (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i)
  );

  // Called just after a rising edge with the DUT idle; returns 1ns after the handshake edge.
  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    @(posedge wb_clk_i);
    #1 cmd_valid = 1'b0;
  endtask

  // Samples on falling edges until rsp_valid (bounded); records what the bus showed.
  task automatic wait_rsp(output int cyc_n, output int stb_n, output logic we_seen,
                          output logic [3:0] sel_seen, output logic [31:0] dat_seen,
                          output logic [31:0] adr_seen);
    cyc_n = 0; stb_n = 0; we_seen = 1'b0;
    sel_seen = 4'hf; dat_seen = 32'hx; adr_seen = 32'hx;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i);
      cyc_n++;
      if (wbm_stb_o) begin
        stb_n++;
        we_seen  = we_seen | wbm_we_o;
        sel_seen = wbm_sel_o;
        dat_seen = wbm_dat_o;
        adr_seen = wbm_adr_o;
      end
      if (rsp_valid) break;
    end
  endtask

  // Called at a falling edge; returns 1ns after the response handshake edge.
  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge wb_clk_i);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge wb_clk_i);
    tests += 10;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset cmd_ready: got %b want 1", cmd_ready); end
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
    if (rsp_err !== 1'b0)   begin fails++; $display("FAIL reset rsp_err: got %b want 0", rsp_err); end
    if (rsp_dat !== 32'h0)  begin fails++; $display("FAIL reset rsp_dat: got %h want 0", rsp_dat); end
    if (wbm_cyc_o !== 1'b0) begin fails++; $display("FAIL reset cyc: got %b want 0", wbm_cyc_o); end
    if (wbm_stb_o !== 1'b0) begin fails++; $display("FAIL reset stb: got %b want 0", wbm_stb_o); end
    if (wbm_we_o !== 1'b0)  begin fails++; $display("FAIL reset we: got %b want 0", wbm_we_o); end
    if (wbm_adr_o !== 32'h0) begin fails++; $display("FAIL reset adr: got %h want 0", wbm_adr_o); end
    if (wbm_dat_o !== 32'h0) begin fails++; $display("FAIL reset dat: got %h want 0", wbm_dat_o); end
    if (wbm_sel_o !== 4'h0) begin fails++; $display("FAIL reset sel: got %h want 0", wbm_sel_o); end
    @(posedge wb_clk_i); #1;
  endtask

  task automatic test_read();
    int cn, sn; logic ws; logic [3:0] ss; logic [31:0] ds, as;
    ack_en = 1'b1; ack_delay = 1; slave_dat = 32'hcafe_f00d;
    send_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hf);
    wait_rsp(cn, sn, ws, ss, ds, as);
    tests += 7;
    if (cn !== 3) begin fails++; $display("FAIL read latency: got %0d want 3", cn); end
    if (sn !== 2) begin fails++; $display("FAIL read stb_cycles: got %0d want 2", sn); end
    if (ws !== 1'b0) begin fails++; $display("FAIL read we: got %b want 0", ws); end
    if (as !== 32'h3000_0004) begin fails++; $display("FAIL read adr: got %h want 30000004", as); end
    if (rsp_dat !== 32'hcafe_f00d) begin fails++; $display("FAIL read rsp_dat: got %h want cafef00d", rsp_dat); end
    if (rsp_err !== 1'b0) begin fails++; $display("FAIL read rsp_err: got %b want 0", rsp_err); end
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL read cmd_ready_in_resp: got %b want 0", cmd_ready); end
    finish_rsp();
    @(negedge wb_clk_i);
    tests += 2;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL read cmd_ready_after: got %b want 1", cmd_ready); end
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL read rsp_valid_after: got %b want 0", rsp_valid); end
    @(posedge wb_clk_i); #1;
  endtask

  task automatic test_write();
    int cn, sn; logic ws; logic [3:0] ss; logic [31:0] ds, as;
    ack_en = 1'b1; ack_delay = 0; slave_dat = 32'hdead_beef;
    send_cmd(1'b1, 32'h3000_0000, 32'h1234_5678, 4'b0011);
    wait_rsp(cn, sn, ws, ss, ds, as);
    tests += 8;
    if (cn !== 2) begin fails++; $display("FAIL write latency: got %0d want 2", cn); end
    if (sn !== 1) begin fails++; $display("FAIL write stb_cycles: got %0d want 1", sn); end
    if (ws !== 1'b1) begin fails++; $display("FAIL write we: got %b want 1", ws); end
    if (ss !== 4'b0011) begin fails++; $display("FAIL write sel: got %b want 0011", ss); end
    if (ds !== 32'h1234_5678) begin fails++; $display("FAIL write dat: got %h want 12345678", ds); end
    if (as !== 32'h3000_0000) begin fails++; $display("FAIL write adr: got %h want 30000000", as); end
    if (rsp_dat !== 32'h0) begin fails++; $display("FAIL write rsp_dat: got %h want 0", rsp_dat); end
    if (wbm_we_o !== 1'b0) begin fails++; $display("FAIL write we_in_resp: got %b want 0", wbm_we_o); end
    finish_rsp();
  endtask

  task automatic test_resp_hold();
    int cn, sn; logic ws; logic [3:0] ss; logic [31:0] ds, as;
    ack_en = 1'b1; ack_delay = 0; slave_dat = 32'ha5a5_5a5a;
    send_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hf);
    wait_rsp(cn, sn, ws, ss, ds, as);
    slave_dat = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge wb_clk_i);
      tests += 4;
      if (rsp_valid !== 1'b1) begin fails++; $display("FAIL hold rsp_valid[%0d]: got %b want 1", i, rsp_valid); end
      if (rsp_dat !== 32'ha5a5_5a5a) begin fails++; $display("FAIL hold rsp_dat[%0d]: got %h want a5a55a5a", i, rsp_dat); end
      if (cmd_ready !== 1'b0) begin fails++; $display("FAIL hold cmd_ready[%0d]: got %b want 0", i, cmd_ready); end
      if (wbm_cyc_o !== 1'b0) begin fails++; $display("FAIL hold cyc[%0d]: got %b want 0", i, wbm_cyc_o); end
    end
    tests++;
    if (wbm_adr_o !== 32'h3000_0008) begin fails++; $display("FAIL hold adr_kept: got %h want 30000008", wbm_adr_o); end
    finish_rsp();
  endtask

  task automatic test_sel_zero();
    int cn, sn; logic ws; logic [3:0] ss; logic [31:0] ds, as;
    ack_en = 1'b1; ack_delay = 0;
    send_cmd(1'b1, 32'h3000_000c, 32'h0f0f_0f0f, 4'b0000);
    wait_rsp(cn, sn, ws, ss, ds, as);
    tests += 2;
    if (ss !== 4'b0000) begin fails++; $display("FAIL sel_zero sel: got %b want 0000", ss); end
    if (sn !== 1) begin fails++; $display("FAIL sel_zero stb_cycles: got %0d want 1", sn); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int cn, sn; logic ws; logic [3:0] ss; logic [31:0] ds, as;
    ack_en = 1'b1; ack_delay = 0; slave_dat = 32'h1111_2222;
    send_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hf);
    wait_rsp(cn, sn, ws, ss, ds, as);
    tests++;
    if (rsp_dat !== 32'h1111_2222) begin fails++; $display("FAIL b2b rsp_dat1: got %h want 11112222", rsp_dat); end
    // Next command already offered while the response is being consumed.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0020; cmd_dat = 32'h5555_aaaa;
    cmd_sel = 4'hf;
    rsp_ready = 1'b1;
    @(posedge wb_clk_i);
    #1 rsp_ready = 1'b0;
    @(negedge wb_clk_i);
    tests += 3;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b cmd_ready: got %b want 1", cmd_ready); end
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b rsp_valid_gap: got %b want 0", rsp_valid); end
    if (wbm_cyc_o !== 1'b0) begin fails++; $display("FAIL b2b cyc_gap: got %b want 0", wbm_cyc_o); end
    @(posedge wb_clk_i);
    #1 cmd_valid = 1'b0;
    wait_rsp(cn, sn, ws, ss, ds, as);
    tests += 3;
    if (cn !== 2) begin fails++; $display("FAIL b2b latency2: got %0d want 2", cn); end
    if (as !== 32'h3000_0020) begin fails++; $display("FAIL b2b adr2: got %h want 30000020", as); end
    if (rsp_dat !== 32'h0) begin fails++; $display("FAIL b2b rsp_dat2: got %h want 0", rsp_dat); end
    finish_rsp();
  endtask

  task automatic test_bus_reset();
    ack_en = 1'b0;
    send_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hf);
    @(negedge wb_clk_i);
    tests++;
    if (wbm_stb_o !== 1'b1) begin fails++; $display("FAIL busrst stb_before: got %b want 1", wbm_stb_o); end
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    tests += 4;
    if (wbm_cyc_o !== 1'b0) begin fails++; $display("FAIL busrst cyc: got %b want 0", wbm_cyc_o); end
    if (wbm_stb_o !== 1'b0) begin fails++; $display("FAIL busrst stb: got %b want 0", wbm_stb_o); end
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL busrst cmd_ready: got %b want 1", cmd_ready); end
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL busrst rsp_valid: got %b want 0", rsp_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      tests++;
      if (rsp_valid !== 1'b0) begin fails++; $display("FAIL busrst rsp_valid_later[%0d]: got %b want 0", i, rsp_valid); end
    end
    ack_en = 1'b1;
    @(posedge wb_clk_i); #1;
  endtask

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int cn, sn; logic ws; logic [3:0] ss; logic [31:0] ds, as;
    ack_en = 1'b0; slave_dat = 32'hffff_ffff;
    send_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hf);
    wait_rsp(cn, sn, ws, ss, ds, as);
    tests += 4;
    if (cn !== 6) begin fails++; $display("FAIL timeout latency: got %0d want 6", cn); end
    if (sn !== 5) begin fails++; $display("FAIL timeout stb_cycles: got %0d want 5", sn); end
    if (rsp_err !== 1'b1) begin fails++; $display("FAIL timeout rsp_err: got %b want 1", rsp_err); end
    if (rsp_dat !== 32'h0) begin fails++; $display("FAIL timeout rsp_dat: got %h want 0", rsp_dat); end
    finish_rsp();
    ack_en = 1'b1; ack_delay = 0; slave_dat = 32'h0bad_beef;
    send_cmd(1'b0, 32'h3000_0044, 32'h0, 4'hf);
    wait_rsp(cn, sn, ws, ss, ds, as);
    tests += 3;
    if (cn !== 2) begin fails++; $display("FAIL timeout next_latency: got %0d want 2", cn); end
    if (rsp_err !== 1'b0) begin fails++; $display("FAIL timeout next_err: got %b want 0", rsp_err); end
    if (rsp_dat !== 32'h0bad_beef) begin fails++; $display("FAIL timeout next_dat: got %h want 0badbeef", rsp_dat); end
    finish_rsp();
  endtask

  task automatic test_ack_at_expiry();
    int cn, sn; logic ws; logic [3:0] ss; logic [31:0] ds, as;
    ack_en = 1'b1; ack_delay = 4; slave_dat = 32'h7777_8888;
    send_cmd(1'b0, 32'h3000_0048, 32'h0, 4'hf);
    wait_rsp(cn, sn, ws, ss, ds, as);
    tests += 4;
    if (cn !== 6) begin fails++; $display("FAIL ack_expiry latency: got %0d want 6", cn); end
    if (sn !== 5) begin fails++; $display("FAIL ack_expiry stb_cycles: got %0d want 5", sn); end
    if (rsp_err !== 1'b0) begin fails++; $display("FAIL ack_expiry rsp_err: got %b want 0", rsp_err); end
    if (rsp_dat !== 32'h7777_8888) begin fails++; $display("FAIL ack_expiry rsp_dat: got %h want 77778888", rsp_dat); end
    finish_rsp();
    ack_delay = 0;
  endtask
`endif

  initial begin
    wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b0; ack_en = 1'b0; ack_delay = 0; slave_dat = '0;
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_resp_hold();
    test_sel_zero();
    test_back_to_back();
    test_bus_reset();
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    test_timeout();
    test_ack_at_expiry();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
